// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-requester bus arbiter with ownership held until the
// final beat (last_x accepted) or until the owner drops its request.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin resolution of
// simultaneous requests; otherwise A always wins a tie.
module bus_arbiter_2 #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [BUS_WIDTH-1:0] data_a,
    input  logic [BUS_WIDTH-1:0] data_b,
    input  logic                 last_a,
    input  logic                 last_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic                 sel,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic        accept;
    logic        tie_to_b;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = A was granted most recently, so B wins the next tie.
    logic prefer_b_q, prefer_b_d;
    assign tie_to_b = prefer_b_q;
`else
    assign tie_to_b = 1'b0;
`endif

    assign gnt_a     = (state_q == OWN_A);
    assign gnt_b     = (state_q == OWN_B);
    assign sel       = sel_q;
    assign beat_cnt  = beat_cnt_q;
    assign out_data  = sel_q ? data_b : data_a;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign accept    = out_valid & out_ready;

    // Next-state, select and beat counter; handover goes straight to the
    // other requester so there is no idle bubble between owners.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q + {15'd0, accept};
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) state_d = tie_to_b ? OWN_B : OWN_A;
                else if (req_a)     state_d = OWN_A;
                else if (req_b)     state_d = OWN_B;
            end
            OWN_A: begin
                if (!req_a || (accept && last_a)) state_d = req_b ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (!req_b || (accept && last_b)) state_d = req_a ? OWN_A : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWN_A && state_q != OWN_A) sel_d = 1'b0;
        if (state_d == OWN_B && state_q != OWN_B) sel_d = 1'b1;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer records the requester of each newly issued grant.
    always_comb begin
        prefer_b_d = prefer_b_q;
        if (state_d == OWN_A && state_q != OWN_A) prefer_b_d = 1'b1;
        if (state_d == OWN_B && state_q != OWN_B) prefer_b_d = 1'b0;
    end

    // Pointer register, reset to favour A.
    always_ff @(posedge clk) begin
        if (reset) prefer_b_q <= 1'b0;
        else       prefer_b_q <= prefer_b_d;
    end
`endif

    // State, select and counter registers; reset overrides any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            beat_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb_bus_arbiter_2: directed scenarios with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge.
module tb_bus_arbiter_2;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_a, req_b, last_a, last_b, out_ready;
    logic [W-1:0] data_a, data_b;
    logic         gnt_a, gnt_b, sel, out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  beat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_2 #(.BUS_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b),
        .last_a(last_a), .last_b(last_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .beat_cnt(beat_cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_a = 0; req_b = 0; last_a = 0; last_b = 0; out_ready = 0;
        data_a = 32'h0; data_b = 32'h0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL reset_gnt_a got %b exp 0", gnt_a); end
        checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL reset_gnt_b got %b exp 0", gnt_b); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", sel); end
        checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", beat_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_single_beat();
        do_reset();
        req_a = 1; data_a = 32'hDEADBEEF; data_b = 32'h12345678; out_ready = 1; last_a = 1;
        tick();
        checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL single_gnt_a got %b exp 1", gnt_a); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL single_sel got %b exp 0", sel); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        tick();
        req_a = 0;
        checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", beat_cnt); end
        checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL single_idle got %b%b exp 00", gnt_a, gnt_b); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_a, exp_b;
        exp_a = 3'b101; // after ticks 1..3: A, B, A
        exp_b = 3'b010;
        do_reset();
        req_a = 1; req_b = 1; last_a = 1; last_b = 1; out_ready = 1;
        data_a = 32'hAAAA0000; data_b = 32'hBBBB0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt_a !== exp_a[2-i] || gnt_b !== exp_b[2-i]) begin
                errors++; $display("FAIL b2b_grant%0d got %b%b exp %b%b", i, gnt_a, gnt_b, exp_a[2-i], exp_b[2-i]); end
            checks++; if (sel !== exp_b[2-i]) begin errors++; $display("FAIL b2b_sel%0d got %b exp %b", i, sel, exp_b[2-i]); end
            checks++; if (out_data !== (exp_b[2-i] ? 32'hBBBB0000 : 32'hAAAA0000)) begin
                errors++; $display("FAIL b2b_data%0d got %h", i, out_data); end
            checks++; if (beat_cnt !== 16'(i)) begin errors++; $display("FAIL b2b_cnt%0d got %0d exp %0d", i, beat_cnt, i); end
        end
        // A granted last; drop both, then raise both together from IDLE.
        req_a = 0; req_b = 0;
        tick();
        checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b%b exp 00", gnt_a, gnt_b); end
        checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL b2b_abort_cnt got %0d exp 2", beat_cnt); end
        req_a = 1; req_b = 1; last_a = 0; last_b = 0;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        checks++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("FAIL tie_rr got %b%b exp 01", gnt_a, gnt_b); end
`else
        checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL tie_fixed got %b%b exp 10", gnt_a, gnt_b); end
`endif
        req_a = 0; req_b = 0;
    endtask

    task automatic test_stall();
        do_reset();
        req_a = 1; last_a = 1; out_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL stall_gnt%0d got %b exp 1", i, gnt_a); end
            checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt%0d got %0d exp 0", i, beat_cnt); end
        end
        out_ready = 1;
        tick();
        req_a = 0;
        checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL stall_release_cnt got %0d exp 1", beat_cnt); end
        checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL stall_release_gnt got %b exp 0", gnt_a); end
    endtask

    task automatic test_abort();
        do_reset();
        req_b = 1; last_b = 0; out_ready = 1; last_a = 1;
        tick();
        checks++; if (gnt_b !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL abort_own_b got gnt_b=%b sel=%b exp 1 1", gnt_b, sel); end
        tick();
        checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL abort_pre_cnt got %0d exp 1", beat_cnt); end
        req_b = 0; req_a = 1;
        tick();
        checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL abort_handover got %b%b exp 10", gnt_a, gnt_b); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL abort_sel got %b exp 0", sel); end
        checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt got %0d exp 1", beat_cnt); end
        req_a = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_b = 1; last_b = 0; out_ready = 1;
        tick();
        tick();
        checks++; if (gnt_b !== 1'b1 || beat_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre got gnt_b=%b cnt=%0d exp 1 1", gnt_b, beat_cnt); end
        reset = 1;
        tick();
        reset = 0; req_b = 0;
        checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL rmid_gnt_b got %b exp 0", gnt_b); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rmid_sel got %b exp 0", sel); end
        checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", beat_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_a = 1; last_a = 0; out_ready = 1;
        tick();
        for (int i = 0; i < 65535; i++) tick();
        checks++; if (beat_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", beat_cnt); end
        tick();
        checks++; if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", beat_cnt); end
        req_a = 0;
    endtask

    initial begin
        reset = 1;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
